// File: rtl/mul_pkg.sv
// Shared types and helpers for units built on the 32-bit sum-only carry-lookahead adder.
package mul_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The adder returns only the sum; recover carry-out from the operand and sum MSBs.
  function automatic logic carry_out(input logic a_msb, input logic b_msb, input logic sum_msb);
    return (a_msb & b_msb) | ((a_msb ^ b_msb) & ~sum_msb);
  endfunction

endpackage

// File: rtl/shift_add_mul.sv
// 32x32 -> 64 unsigned shift-and-add multiplier with valid/ready handshakes,
// driving an external sum-only adder one addition per multiplier bit.
module shift_add_mul
  import mul_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PROD_W-1:0]   out_prod,
  output logic                busy,
  output logic [WIDTH-1:0]    add_a,
  output logic [WIDTH-1:0]    add_b,
  output logic                add_cin,
  input  logic [WIDTH-1:0]    add_sum
);

  state_t              state_q, state_d;
  logic [PROD_W-1:0]   p_q, p_d;
  logic [WIDTH-1:0]    m_q, m_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                carry;

  // Upper half of P is always the running partial sum; M is added only when the current multiplier bit is set.
  assign add_a    = p_q[PROD_W-1:WIDTH];
  assign add_b    = (state_q == RUN && p_q[0]) ? m_q : '0;
  assign add_cin  = 1'b0;
  assign carry    = carry_out(add_a[WIDTH-1], add_b[WIDTH-1], add_sum[WIDTH-1]);
  assign out_prod = p_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          m_d     = in_a;
          p_d     = {WIDTH'(0), in_b};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        // Carry lands in P[63] so the full-width partial sum is never truncated.
        p_d   = {carry, add_sum, p_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_add_mul.sv
// Self-checking bench for shift_add_mul; the adder is modelled as a plain 32-bit sum.
module tb_shift_add_mul;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_prod;
  logic        busy;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;

  int errors = 0;
  int checks = 0;

  shift_add_mul dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .busy      (busy),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum)
  );

  // Sum-only adder: carry-out is deliberately dropped.
  assign add_sum = add_a + add_b + {31'b0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  // One complete operation: accept, run, optional hold in DONE, then drain.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit pulse_in_run);
    logic [63:0] exp;
    int          n;
    int          cycles;
    exp = ref_mul(a, b);
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_ready_before_accept"}, 64'(in_ready), 64'(1));
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a = $urandom();
    in_b = $urandom();
    check({tag, "_busy_after_accept"}, 64'(busy), 64'(1));
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      if (pulse_in_run) begin
        in_valid = 1'($urandom_range(0, 1));
        in_a = $urandom();
        in_b = $urandom();
      end
      tick();
      cycles++;
      if (!out_valid) check({tag, "_in_ready_run"}, 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 64'(cycles), 64'(32));
    check({tag, "_prod"}, out_prod, exp);
    check({tag, "_in_ready_done"}, 64'(in_ready), 64'(0));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
      check({tag, "_hold_prod"}, out_prod, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_idle_ready"}, 64'(in_ready), 64'(1));
    check({tag, "_idle_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_prod", out_prod, 64'(0));
    check("rst_add_b", 64'(add_b), 64'(0));
    check("rst_add_cin", 64'(add_cin), 64'(0));

    do_op("3x5", 32'd3, 32'd5, 0, 1'b0);
    do_op("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    do_op("bzero", 32'h1234_5678, 32'h0, 0, 1'b1);
    do_op("azero", 32'h0, 32'hDEAD_BEEF, 0, 1'b1);
    do_op("hold7", 32'h8000_0000, 32'd2, 7, 1'b0);

    // Reset in the middle of 0xAAAAAAAA*0x55555555 discards the partial product.
    in_a = 32'hAAAA_AAAA;
    in_b = 32'h5555_5555;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    check("mid_run_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_prod", out_prod, 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    do_op("7x6", 32'd7, 32'd6, 0, 1'b0);

    // Back-to-back with in_valid held high across the handshake.
    in_a = 32'd1000;
    in_b = 32'd1000;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_a = 32'h0001_0000;
    in_b = 32'h0001_0000;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check("b2b_lat1", 64'(n), 64'(32));
    check("b2b_prod1", out_prod, 64'h0000_0000_000F_4240);
    tick();
    check("b2b_gap_ready", 64'(in_ready), 64'(1));
    check("b2b_gap_valid", 64'(out_valid), 64'(0));
    tick();
    in_valid = 1'b0;
    check("b2b_accept2", 64'(busy), 64'(1));
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check("b2b_lat2", 64'(n), 64'(32));
    check("b2b_prod2", out_prod, 64'h0000_0001_0000_0000);
    tick();
    out_ready = 1'b0;
    check("b2b_end_valid", 64'(out_valid), 64'(0));

    // Random operands against the arithmetic reference.
    for (int k = 0; k < 12; k++) begin
      ra = $urandom();
      rb = $urandom();
      if (k == 0) ra = 32'hFFFF_FFFF;
      do_op("rand", ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
